// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary pointer conversion used by both pointer controllers.
package fifo_pkg;

  localparam int unsigned CONV_W = 32;

  typedef logic [CONV_W-1:0] conv_t;

  // Zero-extended operands convert correctly, so callers cast to/from their pointer width.
  function automatic conv_t bin2gray(input conv_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic conv_t gray2bin(input conv_t g);
    conv_t b;
    b = g;
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module sync_ff_chain #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer and status controller for the async FIFO; every status output is
// derived from the synchronised write pointer and the next read pointer, then registered.
module rd_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 4
) (
  input  logic                 CLK_r,
  input  logic                 RST_n_r,
  input  logic                 EN_r,
  input  logic                 Clr_Err,
  input  logic [ADDR_SIZE:0]   G_W_address,
  output logic                 Empty,
  output logic                 Almost_Empty,
  output logic [ADDR_SIZE:0]   Rd_Count,
  output logic                 Underflow,
  output logic                 Rd_Ack,
  output logic [ADDR_SIZE-1:0] R_addr,
  output logic [ADDR_SIZE:0]   B_R_address,
  output logic [ADDR_SIZE:0]   G_R_address
);

  localparam int unsigned   PW       = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("rd_ptr_ctrl: SYNC_STAGES must be at least 2");
  end
  if (AE_THRESH >= (32'd1 << ADDR_SIZE)) begin : g_bad_ae_thresh
    $error("rd_ptr_ctrl: AE_THRESH must be below the FIFO depth");
  end

  logic [PW-1:0] wq;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] cnt_next;
  logic          underflow_next;

  sync_ff_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (CLK_r),
    .rst_n (RST_n_r),
    .d     (G_W_address),
    .q     (wq)
  );

  assign Rd_Ack = EN_r & ~Empty;
  assign R_addr = B_R_address[ADDR_SIZE-1:0];

  // Next-state status; the extra pointer MSB lets a modular subtract reach the full depth.
  always_comb begin
    wq_bin         = PW'(gray2bin(CONV_W'(wq)));
    rd_next        = B_R_address + PW'(Rd_Ack);
    gray_next      = PW'(bin2gray(CONV_W'(rd_next)));
    cnt_next       = wq_bin - rd_next;
    underflow_next = (EN_r & Empty) | (Underflow & ~Clr_Err);
  end

  always_ff @(posedge CLK_r or negedge RST_n_r) begin
    if (!RST_n_r) begin
      B_R_address  <= '0;
      G_R_address  <= '0;
      Empty        <= 1'b1;
      Almost_Empty <= 1'b1;
      Rd_Count     <= '0;
      Underflow    <= 1'b0;
    end else begin
      B_R_address  <= rd_next;
      G_R_address  <= gray_next;
      Empty        <= (gray_next == wq);
      Rd_Count     <= cnt_next;
      Almost_Empty <= (cnt_next <= AE_LIMIT);
      Underflow    <= underflow_next;
    end
  end

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Bench for rd_ptr_ctrl: hand-derived vector table, model-fed scoreboard and corner sequences.
module tb_rd_ptr_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned AE = 4;

  logic          CLK_r = 1'b0;
  logic          RST_n_r;
  logic          EN_r;
  logic          Clr_Err;
  logic [PW-1:0] G_W_address;
  logic          Empty;
  logic          Almost_Empty;
  logic [PW-1:0] Rd_Count;
  logic          Underflow;
  logic          Rd_Ack;
  logic [AW-1:0] R_addr;
  logic [PW-1:0] B_R_address;
  logic [PW-1:0] G_R_address;

  rd_ptr_ctrl #(
    .ADDR_SIZE   (AW),
    .SYNC_STAGES (2),
    .AE_THRESH   (AE)
  ) dut (
    .CLK_r        (CLK_r),
    .RST_n_r      (RST_n_r),
    .EN_r         (EN_r),
    .Clr_Err      (Clr_Err),
    .G_W_address  (G_W_address),
    .Empty        (Empty),
    .Almost_Empty (Almost_Empty),
    .Rd_Count     (Rd_Count),
    .Underflow    (Underflow),
    .Rd_Ack       (Rd_Ack),
    .R_addr       (R_addr),
    .B_R_address  (B_R_address),
    .G_R_address  (G_R_address)
  );

  always #5 CLK_r = ~CLK_r;

  typedef struct packed {
    logic          ack;
    logic          empty;
    logic          ae;
    logic [PW-1:0] cnt;
    logic          uf;
    logic [PW-1:0] bptr;
    logic [PW-1:0] gptr;
  } exp_t;

  typedef struct packed {
    logic          en;
    logic          clr;
    logic [PW-1:0] gw;
    exp_t          e;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wraps_seen = 0;

  // Reference state: read pointer, write pointer as seen two cycles late, status flags.
  logic [PW-1:0] m_r, m_d0, m_d1;
  logic          m_empty, m_uf;

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_r = '0; m_d0 = '0; m_d1 = '0; m_empty = 1'b1; m_uf = 1'b0;
  endtask

  // Drive one cycle; push the table record if given, else the model's prediction.
  task automatic run_cycle(input logic en, input logic clr, input logic [PW-1:0] gw_gray,
                           input logic use_tbl, input exp_t tbl_e);
    exp_t          e;
    exp_t          got;
    logic          ack;
    logic [PW-1:0] nr, cnt;
    ack     = en & ~m_empty;
    nr      = m_r + PW'(ack);
    cnt     = m_d1 - nr;
    e.ack   = ack;
    e.empty = (cnt == '0);
    e.ae    = (32'(cnt) <= AE);
    e.cnt   = cnt;
    e.uf    = (en & m_empty) | (m_uf & ~clr);
    e.bptr  = nr;
    e.gptr  = b2g(nr);
    m_r = nr; m_d1 = m_d0; m_d0 = g2b(gw_gray); m_empty = e.empty; m_uf = e.uf;
    exp_q.push_back(use_tbl ? tbl_e : e);
    EN_r = en; Clr_Err = clr; G_W_address = gw_gray;
    @(negedge CLK_r);
    chk("rd_ack", 32'(Rd_Ack), 32'(exp_q[0].ack));
    @(posedge CLK_r);
    #1;
    got = exp_q.pop_front();
    chk("empty",        32'(Empty),        32'(got.empty));
    chk("almost_empty", 32'(Almost_Empty), 32'(got.ae));
    chk("rd_count",     32'(Rd_Count),     32'(got.cnt));
    chk("underflow",    32'(Underflow),    32'(got.uf));
    chk("b_r_address",  32'(B_R_address),  32'(got.bptr));
    chk("g_r_address",  32'(G_R_address),  32'(got.gptr));
    chk("r_addr",       32'(R_addr),       32'(got.bptr[AW-1:0]));
  endtask

  task automatic step(input logic en, input logic clr, input logic [PW-1:0] gw_gray);
    run_cycle(en, clr, gw_gray, 1'b0, '0);
  endtask

  task automatic do_reset();
    RST_n_r = 1'b0; EN_r = 1'b0; Clr_Err = 1'b0; G_W_address = '0;
    model_reset();
    repeat (2) @(negedge CLK_r);
    RST_n_r = 1'b1;
    @(posedge CLK_r);
    #1;
  endtask

  // Each G_R_address change must flip exactly one bit; also count read-pointer wraps.
  logic [PW-1:0] g_prev = '0;
  logic [PW-1:0] b_prev = '0;
  always @(negedge CLK_r) begin
    if (!RST_n_r) begin
      g_prev = '0;
      b_prev = '0;
    end else begin
      if (G_R_address != g_prev) begin
        chk("g_r_single_bit", 32'($countones(G_R_address ^ g_prev)), 32'd1);
      end
      if (b_prev == PW'(15) && B_R_address == '0) wraps_seen++;
      g_prev = G_R_address;
      b_prev = B_R_address;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[13];
    logic [PW-1:0] wbin;
    int            k;

    tbl[0]  = '{1'b0, 1'b0, 4'b0000, '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 4'b0000}};
    tbl[1]  = '{1'b0, 1'b0, 4'b0111, '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 4'b0000}};
    tbl[2]  = '{1'b0, 1'b0, 4'b0111, '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 4'b0000}};
    tbl[3]  = '{1'b0, 1'b0, 4'b0111, '{1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 4'd0, 4'b0000}};
    tbl[4]  = '{1'b1, 1'b0, 4'b0111, '{1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 4'd1, 4'b0001}};
    tbl[5]  = '{1'b1, 1'b0, 4'b0111, '{1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd2, 4'b0011}};
    tbl[6]  = '{1'b1, 1'b0, 4'b0111, '{1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 4'd3, 4'b0010}};
    tbl[7]  = '{1'b1, 1'b0, 4'b0111, '{1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 4'd4, 4'b0110}};
    tbl[8]  = '{1'b1, 1'b0, 4'b0111, '{1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd5, 4'b0111}};
    tbl[9]  = '{1'b1, 1'b0, 4'b0111, '{1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'd5, 4'b0111}};
    tbl[10] = '{1'b1, 1'b1, 4'b0111, '{1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'd5, 4'b0111}};
    tbl[11] = '{1'b0, 1'b1, 4'b0111, '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd5, 4'b0111}};
    tbl[12] = '{1'b0, 1'b0, 4'b0111, '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd5, 4'b0111}};

    // Reset values while reset is held.
    RST_n_r = 1'b0; EN_r = 1'b0; Clr_Err = 1'b0; G_W_address = '0;
    #12;
    chk("rst_empty",     32'(Empty),        32'd1);
    chk("rst_ae",        32'(Almost_Empty), 32'd1);
    chk("rst_count",     32'(Rd_Count),     32'd0);
    chk("rst_underflow", 32'(Underflow),    32'd0);
    chk("rst_bptr",      32'(B_R_address),  32'd0);
    chk("rst_gptr",      32'(G_R_address),  32'd0);
    do_reset();

    // Sync latency, five reads to empty, underflow set/clear priority.
    for (int i = 0; i < 13; i++) begin
      run_cycle(tbl[i].en, tbl[i].clr, tbl[i].gw, 1'b1, tbl[i].e);
    end

    // Wrap-around laps with a Gray-incrementing write pointer.
    wbin = 4'd5;
    for (int lap = 0; lap < 20; lap++) begin
      k = int'($urandom_range(1, 8));
      for (int j = 0; j < k; j++) begin
        wbin = wbin + 4'd1;
        step(1'($urandom_range(0, 1)), 1'b0, b2g(wbin));
      end
      for (int j = 0; j < k + 4; j++) step(1'b1, 1'b0, b2g(wbin));
      step(1'b0, 1'b1, b2g(wbin));
    end
    chk("wrap_seen", 32'(wraps_seen > 0), 32'd1);

    // Full FIFO from read pointer 0.
    do_reset();
    repeat (3) step(1'b0, 1'b0, 4'b1100);
    chk("full_count", 32'(Rd_Count), 32'd8);
    chk("full_empty", 32'(Empty),    32'd0);
    repeat (8) step(1'b1, 1'b0, 4'b1100);
    chk("drained_empty", 32'(Empty),       32'd1);
    chk("drained_bptr",  32'(B_R_address), 32'd8);
    chk("drained_gptr",  32'(G_R_address), 32'b1100);

    // Asynchronous reset in the middle of a read burst.
    do_reset();
    repeat (3) step(1'b0, 1'b0, 4'b0111);
    repeat (2) step(1'b1, 1'b0, 4'b0111);
    chk("burst_count", 32'(Rd_Count), 32'd3);
    EN_r = 1'b1;
    @(negedge CLK_r);
    #1;
    RST_n_r = 1'b0;
    #1;
    chk("async_empty",     32'(Empty),        32'd1);
    chk("async_ae",        32'(Almost_Empty), 32'd1);
    chk("async_count",     32'(Rd_Count),     32'd0);
    chk("async_underflow", 32'(Underflow),    32'd0);
    chk("async_bptr",      32'(B_R_address),  32'd0);
    chk("async_gptr",      32'(G_R_address),  32'd0);
    chk("async_ack",       32'(Rd_Ack),       32'd0);
    model_reset();
    EN_r = 1'b0;
    repeat (2) @(negedge CLK_r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
